max7219_frame_arbiter: RTL and testbench

Shares one chain of MAX7219 8x8 matrices between two pixel-frame requesters, e.g. game screen and menu/splash. It sits in front of the MAX7219 display driver and owns that driver's `enable` and `pixels` inputs. It watches the driver's `started` flag to find frame-refresh boundaries. Ownership changes and pixel snapshots happen only at those boundaries, so a frame never tears. A minimum-hold rule plus round-robin keeps either requester from starving the other.

---
 rtl/max7219_frame_arbiter.sv | 116 +++++++++++
 tb/tb_max7219_frame_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/max7219_frame_arbiter.sv
// max7219_frame_arbiter
//   Shares one MAX7219 matrix chain between two frame requesters. The owner
//   and its frame snapshot change only when the driver's `started` flag falls,
//   which is the end of a full refresh, so a shown frame never tears.
//   Contention uses a minimum hold of HOLD_FRAMES refreshes plus round-robin.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req0/req1         : level requests
//   pix0/pix1         : requester frames (64*SIZE bits, driver packing)
//   disp_started      : driver `started` flag
//   disp_enable       : driver enable, 1 from the first edge after reset
//   disp_pixels       : registered frame snapshot for the driver
//   grant0/grant1     : current owner, one-hot or zero
//   frame_done        : one-cycle pulse per refresh boundary
module max7219_frame_arbiter #(
  parameter int SIZE        = 2,
  parameter int HOLD_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [64*SIZE-1:0] pix0,
  input  logic [64*SIZE-1:0] pix1,
  input  logic              disp_started,
  output logic              disp_enable,
  output logic [64*SIZE-1:0] disp_pixels,
  output logic              grant0,
  output logic              grant1,
  output logic              frame_done
);
  localparam int         W    = 64*SIZE;
  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t       r_state, w_state_nx;
  logic [7:0]   r_hold_cnt, w_hold_nx, w_n;
  logic [8:0]   w_inc;
  logic         r_last, w_last_nx;
  logic         r_started_d, w_boundary;
  logic         r_enable, r_frame_done;
  logic [W-1:0] r_pixels, w_pixels_nx;

  // Falling edge of `started` marks a completed 8-row refresh pass.
  assign w_boundary = r_started_d & ~disp_started;

  // Refresh count including the one just finished, saturated at HOLD.
  assign w_inc = {1'b0, r_hold_cnt} + 9'd1;
  assign w_n   = (w_inc >= {1'b0, HOLD}) ? HOLD : w_inc[7:0];

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold_cnt;
    w_last_nx  = r_last;
    case (r_state)
      IDLE: begin
        // r_last=1 means requester 1 was served last, so requester 0 wins.
        if (req0 && req1)  w_state_nx = r_last ? OWN0 : OWN1;
        else if (req0)     w_state_nx = OWN0;
        else if (req1)     w_state_nx = OWN1;
      end
      OWN0: begin
        if (!req0)                   w_state_nx = req1 ? OWN1 : IDLE;
        else if (req1 && w_n == HOLD) w_state_nx = OWN1;
        else                         w_hold_nx  = w_n;
      end
      OWN1: begin
        if (!req1)                   w_state_nx = req0 ? OWN0 : IDLE;
        else if (req0 && w_n == HOLD) w_state_nx = OWN0;
        else                         w_hold_nx  = w_n;
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_state_nx != r_state) begin
      w_hold_nx = 8'd0;
      if (w_state_nx == OWN0) w_last_nx = 1'b0;
      if (w_state_nx == OWN1) w_last_nx = 1'b1;
    end
    // Snapshot the new owner's frame; blank when nobody owns the display.
    case (w_state_nx)
      OWN0:    w_pixels_nx = pix0;
      OWN1:    w_pixels_nx = pix1;
      default: w_pixels_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hold_cnt   <= 8'd0;
      r_last       <= 1'b1;
      r_started_d  <= 1'b0;
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
      r_pixels     <= '0;
    end else begin
      r_enable     <= 1'b1;
      r_started_d  <= disp_started;
      r_frame_done <= w_boundary;
      if (w_boundary) begin
        r_state    <= w_state_nx;
        r_hold_cnt <= w_hold_nx;
        r_last     <= w_last_nx;
        r_pixels   <= w_pixels_nx;
      end
    end
  end

  assign disp_enable = r_enable;
  assign disp_pixels = r_pixels;
  assign frame_done  = r_frame_done;
  assign grant0      = (r_state == OWN0);
  assign grant1      = (r_state == OWN1);
endmodule

// File: tb/tb_max7219_frame_arbiter.sv
module tb_max7219_frame_arbiter;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst, req0, req1, disp_started;
  logic [W-1:0] pix0, pix1;
  logic         disp_enable, grant0, grant1, frame_done;
  logic [W-1:0] disp_pixels;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] P_AA = {16{8'hAA}};
  localparam logic [W-1:0] P_55 = {16{8'h55}};
  localparam logic [W-1:0] P_B  = 128'h0123456789abcdef_fedcba9876543210;

  max7219_frame_arbiter #(.SIZE(2), .HOLD_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .pix0(pix0), .pix1(pix1),
    .disp_started(disp_started), .disp_enable(disp_enable),
    .disp_pixels(disp_pixels), .grant0(grant0), .grant1(grant1),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver streaming rows: started high for a few cycles.
  task automatic start_frame();
    disp_started = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Drop started; return at the negedge after the boundary edge.
  task automatic end_frame();
    disp_started = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame();
    start_frame();
    end_frame();
  endtask

  initial begin
    logic exp0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; pix0 = '0; pix1 = '0; disp_started = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_enable", W'(disp_enable), '0);
    chk("rst_pixels", disp_pixels, '0);
    chk("rst_grant0", W'(grant0), '0);
    chk("rst_grant1", W'(grant1), '0);
    chk("rst_fdone",  W'(frame_done), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("enable_after_rst", W'(disp_enable), W'(1));
    chk("grant0_pre_boundary", W'(grant0), '0);

    // Boundary with no requests stays idle
    frame();
    chk("idle_fdone", W'(frame_done), W'(1));
    chk("idle_grant0", W'(grant0), '0);
    chk("idle_pixels", disp_pixels, '0);
    @(negedge clk);
    chk("fdone_one_cycle", W'(frame_done), '0);

    // Single requester and snapshot timing
    req0 = 1'b1; pix0 = P_AA;
    start_frame();
    chk("single_not_yet", W'(grant0), '0);
    end_frame();
    chk("single_grant0", W'(grant0), W'(1));
    chk("single_pix_aa", disp_pixels, P_AA);
    start_frame();
    pix0 = P_55;
    @(negedge clk);
    chk("midframe_pix_held", disp_pixels, P_AA);
    end_frame();
    chk("b2_pix_55", disp_pixels, P_55);

    // Release OWN0 to idle
    start_frame();
    req0 = 1'b0;
    chk("rel0_held", W'(grant0), W'(1));
    end_frame();
    chk("rel0_idle_grant", W'(grant0), '0);
    chk("rel0_idle_pix", disp_pixels, '0);

    // Contention from fresh reset, HOLD_FRAMES=4
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    pix0 = P_AA; pix1 = P_B; req0 = 1'b1; req1 = 1'b1;
    for (int b = 1; b <= 13; b++) begin
      frame();
      exp0 = (b < 5) || (b >= 9 && b < 13);
      chk($sformatf("cont_b%0d_g0", b), W'(grant0), W'(exp0));
      chk($sformatf("cont_b%0d_g1", b), W'(grant1), W'(!exp0));
      chk($sformatf("cont_b%0d_fd", b), W'(frame_done), W'(1));
      chk($sformatf("cont_b%0d_pix", b), disp_pixels, exp0 ? P_AA : P_B);
    end

    // Release OWN1 with no other request
    start_frame();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("rel1_held_grant", W'(grant1), W'(1));
    chk("rel1_held_pix", disp_pixels, P_B);
    end_frame();
    chk("rel1_idle_g1", W'(grant1), '0);
    chk("rel1_idle_g0", W'(grant0), '0);
    chk("rel1_idle_pix", disp_pixels, '0);

    // Release OWN1 while req0 waits
    req1 = 1'b1;
    frame();
    chk("own1_again", W'(grant1), W'(1));
    start_frame();
    req1 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    chk("rel1b_held", W'(grant1), W'(1));
    end_frame();
    chk("rel1b_own0", W'(grant0), W'(1));
    chk("rel1b_pix", disp_pixels, P_AA);

    // Round-robin at idle after OWN0 was last: requester 1 wins
    req0 = 1'b0;
    frame();
    chk("rr_idle", W'(grant0), '0);
    req0 = 1'b1; req1 = 1'b1;
    frame();
    chk("rr_own1", W'(grant1), W'(1));
    req1 = 1'b0;
    frame();
    chk("rr_back_own0", W'(grant0), W'(1));

    // Asynchronous reset mid-frame during OWN0
    @(negedge clk);
    disp_started = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_grant0", W'(grant0), '0);
    chk("async_pixels", disp_pixels, '0);
    chk("async_enable", W'(disp_enable), '0);
    @(negedge clk);
    rst = 1'b0; disp_started = 1'b0;
    @(negedge clk);

    // Stalled driver: nothing moves while started stays low
    req0 = 1'b1; req1 = 1'b0; pix0 = P_AA;
    frame();
    chk("stall_setup_g0", W'(grant0), W'(1));
    for (int c = 0; c < 1000; c++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      pix0 = {$urandom, $urandom, $urandom, $urandom};
      pix1 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("stall_fdone", W'(frame_done), '0);
      chk("stall_g0", W'(grant0), W'(1));
      chk("stall_g1", W'(grant1), '0);
      chk("stall_pix", disp_pixels, P_AA);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
